io_pad_enable_seq: RTL

- Power-up/power-down sequencer for the GF22FDX IO ring.
- After the VDDIO supply-good detector reports a stable supply, it releases pad groups from retention one group at a time, staggered to limit simultaneous-switching current on shared VDDIO/VSSIO rails.
- Disables groups in reverse order on sleep request.
- Forces every group safe immediately on supply loss.
- Sits in the always-on domain, between the supply detector, the PMU and the pad-ring enable/retention controls.

---
 rtl/io_seq_pkg.sv | 32 +++
 rtl/io_sync2.sv | 27 ++
 rtl/io_pad_enable_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/io_seq_pkg.sv
// io_seq_pkg
//   Shared definitions for the IO pad-ring enable sequencer.
//   - seq_state_e : sequencer states
//   - MAX_GROUPS  : largest supported number of pad groups
//   - cnt_w_ok()  : true when a counter of cnt_w bits can hold the largest
//                   debounce/stagger terminal count without wrapping
package io_seq_pkg;

   typedef enum logic [2:0] {
      OFF       = 3'd0,
      DEBOUNCE  = 3'd1,
      RAMP_UP   = 3'd2,
      ON        = 3'd3,
      RAMP_DOWN = 3'd4,
      FAULT     = 3'd5
   } seq_state_e;

   localparam int MAX_GROUPS = 16;

   function automatic bit cnt_w_ok(input int cnt_w, input int debounce_cyc,
                                   input int stagger_cyc);
      longint lim;
      lim = (debounce_cyc > stagger_cyc) ? longint'(debounce_cyc) : longint'(stagger_cyc);
      if (cnt_w < 1)
         return 1'b0;
      else if (cnt_w >= 62)
         return 1'b1;
      else
         return (longint'(1) << cnt_w) > lim;
   endfunction

endpackage

// File: rtl/io_sync2.sv
// io_sync2
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, both flops clear to 0
//     d     - asynchronous input
//     q     - synchronized output (two destination-clock edges of latency)
module io_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_pad_enable_seq.sv
// io_pad_enable_seq
//   Always-on power-up/power-down sequencer for the IO pad ring. Once the
//   synchronized supply-good has been stable for DEBOUNCE_CYC cycles, pad
//   groups leave retention one at a time, STAGGER_CYC cycles apart, to limit
//   simultaneous switching on the shared VDDIO/VSSIO rails. Sleep disables
//   them in reverse order. Supply loss forces every group safe at once.
//   Ports:
//     clk          - always-on clock
//     rst_n        - asynchronous active-low reset
//     vddio_ok_i   - asynchronous supply-good, synchronized internally
//     seq_start_i  - level request to power the ring up
//     sleep_req_i  - level request to power the ring down
//     err_clr_i    - single-cycle fault clear
//     grp_en_o     - per-group enable, always a prefix of ones from bit 0
//     retention_o  - ring-wide retention hold (1 = held)
//     seq_busy_o   - high in DEBOUNCE, RAMP_UP, RAMP_DOWN
//     seq_done_o   - high in ON
//     err_o        - sticky supply-loss flag
//   All outputs are registered.
module io_pad_enable_seq
   import io_seq_pkg::*;
#(
   parameter int N_GROUPS     = 4,
   parameter int DEBOUNCE_CYC = 64,
   parameter int STAGGER_CYC  = 16,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vddio_ok_i,
   input  logic                seq_start_i,
   input  logic                sleep_req_i,
   input  logic                err_clr_i,
   output logic [N_GROUPS-1:0] grp_en_o,
   output logic                retention_o,
   output logic                seq_busy_o,
   output logic                seq_done_o,
   output logic                err_o
);

   if (N_GROUPS < 1 || N_GROUPS > MAX_GROUPS) begin : g_chk_groups
      $error("io_pad_enable_seq: N_GROUPS must be in 1..16");
   end
   if (DEBOUNCE_CYC < 1) begin : g_chk_debounce
      $error("io_pad_enable_seq: DEBOUNCE_CYC must be >= 1");
   end
   if (STAGGER_CYC < 1) begin : g_chk_stagger
      $error("io_pad_enable_seq: STAGGER_CYC must be >= 1");
   end
   if (!cnt_w_ok(CNT_W, DEBOUNCE_CYC, STAGGER_CYC)) begin : g_chk_cnt_w
      $error("io_pad_enable_seq: CNT_W too narrow for DEBOUNCE_CYC/STAGGER_CYC");
   end

   localparam logic [CNT_W-1:0]    DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0]    STG_LAST = CNT_W'(STAGGER_CYC - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
   localparam logic [3:0]          G_LAST   = 4'(N_GROUPS - 1);
   localparam logic [N_GROUPS-1:0] GRP_ONE  = N_GROUPS'(1);

   // Sequencer state; kept as a named register so it can be probed directly.
   seq_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          g_q, g_d;
   logic [N_GROUPS-1:0] grp_en_d;
   logic                ret_d, err_d, busy_d, done_d;
   logic                ok_s;
   logic                stg_done;
   logic                supply_lost;
   logic [CNT_W-1:0]    cnt_inc;

   io_sync2 u_sync_vddio (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (vddio_ok_i),
      .q     (ok_s)
   );

   assign stg_done = (cnt_q == STG_LAST);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Supply loss only matters once groups may be enabled; in DEBOUNCE a low
   // ok_s merely restarts the debounce window.
   assign supply_lost = !ok_s &&
                        (state_q == RAMP_UP || state_q == ON || state_q == RAMP_DOWN);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      g_d      = g_q;
      grp_en_d = grp_en_o;
      ret_d    = retention_o;
      err_d    = err_o;

      case (state_q)
         OFF: begin
            cnt_d = '0;
            if (seq_start_i && ok_s && !sleep_req_i)
               state_d = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (sleep_req_i) begin
               state_d = OFF;
               cnt_d   = '0;
            end else if (!ok_s) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d  = RAMP_UP;
               cnt_d    = '0;
               g_d      = 4'd0;
               ret_d    = 1'b0;
               grp_en_d = GRP_ONE;
            end
         end
         RAMP_UP: begin
            // Shifting a one in from bit 0 keeps the enabled set a prefix.
            if (stg_done) begin
               cnt_d = '0;
               if (g_q < G_LAST) begin
                  g_d      = g_q + 4'd1;
                  grp_en_d = (grp_en_o << 1) | GRP_ONE;
               end else begin
                  state_d = ON;
               end
            end
         end
         ON: begin
            cnt_d = '0;
            if (sleep_req_i) begin
               state_d  = RAMP_DOWN;
               g_d      = G_LAST;
               grp_en_d = grp_en_o >> 1;
            end
         end
         RAMP_DOWN: begin
            // g is the index of the group most recently cleared.
            if (stg_done) begin
               cnt_d = '0;
               if (g_q != 4'd0) begin
                  g_d      = g_q - 4'd1;
                  grp_en_d = grp_en_o >> 1;
               end else begin
                  state_d = OFF;
                  ret_d   = 1'b1;
               end
            end
         end
         FAULT: begin
            cnt_d    = '0;
            grp_en_d = '0;
            ret_d    = 1'b1;
            if (err_clr_i && ok_s) begin
               state_d = OFF;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d  = OFF;
            cnt_d    = '0;
            g_d      = 4'd0;
            grp_en_d = '0;
            ret_d    = 1'b1;
         end
      endcase

      // Supply loss overrides every request in the same cycle.
      if (supply_lost) begin
         state_d  = FAULT;
         cnt_d    = '0;
         g_d      = 4'd0;
         grp_en_d = '0;
         ret_d    = 1'b1;
         err_d    = 1'b1;
      end

      busy_d = (state_d == DEBOUNCE) || (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      done_d = (state_d == ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OFF;
         cnt_q       <= '0;
         g_q         <= 4'd0;
         grp_en_o    <= '0;
         retention_o <= 1'b1;
         seq_busy_o  <= 1'b0;
         seq_done_o  <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         g_q         <= g_d;
         grp_en_o    <= grp_en_d;
         retention_o <= ret_d;
         seq_busy_o  <= busy_d;
         seq_done_o  <= done_d;
         err_o       <= err_d;
      end
   end

endmodule
